// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: operation encoding,
// the result flag bundle and the WIDTH/STAGES legality check.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;

  // True when the carry chain can be cut into equal slices.
  function automatic bit stages_divide_width(int width, int stages);
    return (width >= 2) && (stages > 0) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/add_sub_slice.sv
// One combinational CHUNK-bit slice of the carry chain. The caller supplies b
// already inverted for subtraction. c_msb is the carry into the slice MSB so
// that the last slice can report signed overflow.
module add_sub_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] total;

  // Widened add keeps the carry out; the MSB carry-in is recovered from the
  // sum bit and the two operand bits, which also works for single-bit chunks.
  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    sum   = total[CHUNK-1:0];
    cout  = total[CHUNK];
    c_msb = total[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
  end

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor with a valid/ready stream
// interface and carry/overflow/zero/negative flags. An input register captures
// the beat, then each of STAGES slices adds CHUNK bits per cycle; the final
// slice feeds the output register, giving a latency of STAGES cycles.
// Define PIPELINED_ADD_SUB_SAT_EN to clamp overflowing results to the signed
// range instead of wrapping.
module pipelined_add_sub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int CHUNK = WIDTH / STAGES;

  if (!stages_divide_width(WIDTH, STAGES)) begin : g_bad_config
    $error("pipelined_add_sub: WIDTH must be >= 2 and divisible by STAGES");
  end

  // Stage k holds the beat about to be processed by slice k.
  logic [STAGES-1:0] stg_vld;
  logic [STAGES-1:0] stg_op;
  logic [STAGES-1:0] stg_cin;
  logic [WIDTH-1:0]  stg_a [STAGES];
  logic [WIDTH-1:0]  stg_b [STAGES];
  logic [WIDTH-1:0]  stg_s [STAGES];

  logic [CHUNK-1:0]  sl_sum  [STAGES];
  logic [STAGES-1:0] sl_cout;
  logic              sl_cmsb [STAGES];
  logic [WIDTH-1:0]  sum_nx  [STAGES];

  logic              out_vld_q;
  logic [WIDTH-1:0]  s_q;
  flags_t            flags_q;

  logic              adv;
  logic [WIDTH-1:0]  fin_wrap;
  logic [WIDTH-1:0]  fin_s;
  flags_t            fin_flags;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    add_sub_slice #(.CHUNK(CHUNK)) u_slice (
      .a     (stg_a[k][k*CHUNK +: CHUNK]),
      .b     (stg_b[k][k*CHUNK +: CHUNK] ^ {CHUNK{stg_op[k] == OP_SUB}}),
      .cin   (stg_cin[k]),
      .sum   (sl_sum[k]),
      .cout  (sl_cout[k]),
      .c_msb (sl_cmsb[k])
    );

    // Result bits above this slice are still zero, so OR-ing merges them in.
    assign sum_nx[k] = stg_s[k] | (WIDTH'(sl_sum[k]) << (k * CHUNK));
  end

  // The whole pipeline moves together whenever the output slot is free or
  // being emptied this cycle; otherwise everything holds, bubbles included.
  always_comb begin
    adv      = !out_vld_q || out_ready;
    in_ready = adv;
  end

  // Final result and flags from the last slice, optionally saturated.
  always_comb begin
    fin_wrap       = sum_nx[STAGES-1];
    fin_flags      = '0;
    fin_flags.cout = sl_cout[STAGES-1];
    fin_flags.ovf  = sl_cmsb[STAGES-1] ^ sl_cout[STAGES-1];
`ifdef PIPELINED_ADD_SUB_SAT_EN
    if (fin_flags.ovf) begin
      fin_s = fin_wrap[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                : {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      fin_s = fin_wrap;
    end
`else
    fin_s = fin_wrap;
`endif
    fin_flags.zero = (fin_s == '0);
    fin_flags.neg  = fin_s[WIDTH-1];
  end

  // Stage registers shift on advance; the output data only loads for a real
  // beat so the outputs never show bubble contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_vld   <= '0;
      stg_op    <= '0;
      stg_cin   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        stg_a[k] <= '0;
        stg_b[k] <= '0;
        stg_s[k] <= '0;
      end
      out_vld_q <= 1'b0;
      s_q       <= '0;
      flags_q   <= '0;
    end else if (adv) begin
      stg_vld[0] <= in_valid;
      stg_op[0]  <= ctrl;
      stg_cin[0] <= (ctrl == OP_SUB);
      stg_a[0]   <= a;
      stg_b[0]   <= b;
      stg_s[0]   <= '0;
      for (int k = 1; k < STAGES; k++) begin
        stg_vld[k] <= stg_vld[k-1];
        stg_op[k]  <= stg_op[k-1];
        stg_cin[k] <= sl_cout[k-1];
        stg_a[k]   <= stg_a[k-1];
        stg_b[k]   <= stg_b[k-1];
        stg_s[k]   <= sum_nx[k-1];
      end
      out_vld_q <= stg_vld[STAGES-1];
      if (stg_vld[STAGES-1]) begin
        s_q     <= fin_s;
        flags_q <= fin_flags;
      end
    end
  end

  // Drive the ports straight from the output register.
  always_comb begin
    out_valid = out_vld_q;
    s         = s_q;
    cout      = flags_q.cout;
    ovf       = flags_q.ovf;
    zero      = flags_q.zero;
    neg       = flags_q.neg;
  end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed self-checking bench for pipelined_add_sub (WIDTH=16, STAGES=4).
// Honours PIPELINED_ADD_SUB_SAT_EN for the saturating expectations.
module tb_pipelined_add_sub;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;
`ifdef PIPELINED_ADD_SUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic        neg;

  int compared   = 0;
  int mismatched = 0;

  pipelined_add_sub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ctrl      (ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg)
  );

  always #5 clk = ~clk;

  // Reference: 17-bit arithmetic, signed overflow from operand/result signs.
  function automatic logic [19:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mop);
    logic [16:0] ext;
    logic [15:0] rs;
    logic        rovf;
    if (mop) ext = {1'b0, ma} - {1'b0, mb} + 17'h10000;
    else     ext = {1'b0, ma} + {1'b0, mb};
    rs = ext[15:0];
    if (mop) rovf = (ma[15] != mb[15]) && (rs[15] != ma[15]);
    else     rovf = (ma[15] == mb[15]) && (rs[15] != ma[15]);
    if (SAT && rovf) rs = ma[15] ? 16'h8000 : 16'h7FFF;
    return {rs, ext[16], rovf, (rs == 16'h0000), rs[15]};
  endfunction

  // Drive one beat, then wait (bounded) for its result; lat = -1 on timeout.
  task automatic applyStimulus(input logic [15:0] ia, input logic [15:0] ib,
                               input logic iop, output logic [19:0] res,
                               output int lat);
    res = '0;
    lat = -1;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = ia;
    b = ib;
    ctrl = iop;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        res = {s, cout, ovf, zero, neg};
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    ctrl = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid);
    end
    compared++;
    if ({s, cout, ovf, zero, neg} !== 20'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs got=%h want=00000", {s, cout, ovf, zero, neg});
    end
    rst_n = 1'b1;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_add();
    logic [19:0] res;
    int lat;
    applyStimulus(16'h0005, 16'h0003, 1'b0, res, lat);
    compared++;
    if (lat !== 4) begin
      mismatched++;
      $display("[TB] FAIL add_latency got=%0d want=4", lat);
    end
    compared++;
    if (res !== {16'h0008, 4'b0000}) begin
      mismatched++;
      $display("[TB] FAIL add_5_3 got=%h want=%h", res, {16'h0008, 4'b0000});
    end
  endtask

  task automatic test_sub();
    logic [19:0] res;
    int lat;
    applyStimulus(16'h0005, 16'h0003, 1'b1, res, lat);
    compared++;
    if (res !== {16'h0002, 4'b1000}) begin
      mismatched++;
      $display("[TB] FAIL sub_5_3 got=%h want=%h lat=%0d", res, {16'h0002, 4'b1000}, lat);
    end
    applyStimulus(16'h0003, 16'h0005, 1'b1, res, lat);
    compared++;
    if (res !== {16'hFFFE, 4'b0001}) begin
      mismatched++;
      $display("[TB] FAIL sub_3_5 got=%h want=%h lat=%0d", res, {16'hFFFE, 4'b0001}, lat);
    end
  endtask

  task automatic test_boundaries();
    logic [19:0] res;
    logic [19:0] want;
    int lat;
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, res, lat);
    compared++;
    if (res !== {16'h0000, 4'b1010}) begin
      mismatched++;
      $display("[TB] FAIL add_ffff_1 got=%h want=%h lat=%0d", res, {16'h0000, 4'b1010}, lat);
    end
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, res, lat);
    want = SAT ? {16'h7FFF, 4'b0100} : {16'h8000, 4'b0101};
    compared++;
    if (res !== want) begin
      mismatched++;
      $display("[TB] FAIL add_pos_ovf got=%h want=%h lat=%0d", res, want, lat);
    end
    applyStimulus(16'h8000, 16'h0001, 1'b1, res, lat);
    want = SAT ? {16'h8000, 4'b1101} : {16'h7FFF, 4'b1100};
    compared++;
    if (res !== want) begin
      mismatched++;
      $display("[TB] FAIL sub_neg_ovf got=%h want=%h lat=%0d", res, want, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic        vop [8];
    logic [19:0] want [8];
    logic [19:0] held_val;
    bit          held;
    bit          extra;
    int          sent;
    int          recv;
    va  = '{16'h1234, 16'h5000, 16'h7FFF, 16'h0001, 16'h8000, 16'hABCD, 16'h00FF, 16'h4000};
    vb  = '{16'h1111, 16'h2000, 16'h0002, 16'h0002, 16'h8000, 16'h1234, 16'hFF01, 16'hC000};
    vop = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) want[i] = model(va[i], vb[i], vop[i]);
    sent = 0;
    recv = 0;
    held = 1'b0;
    held_val = '0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 6 && cyc <= 8);
      if (sent < 8) begin
        in_valid = 1'b1;
        a = va[sent];
        b = vb[sent];
        ctrl = vop[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        compared++;
        if ({s, cout, ovf, zero, neg} !== want[recv]) begin
          mismatched++;
          $display("[TB] FAIL b2b_beat%0d got=%h want=%h", recv, {s, cout, ovf, zero, neg}, want[recv]);
        end
        recv++;
      end else if (out_valid && !out_ready) begin
        compared++;
        if (in_ready !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL stall_in_ready cyc=%0d got=%b want=0", cyc, in_ready);
        end
        if (!held) begin
          held = 1'b1;
          held_val = {s, cout, ovf, zero, neg};
        end else begin
          compared++;
          if ({s, cout, ovf, zero, neg} !== held_val) begin
            mismatched++;
            $display("[TB] FAIL stall_stable cyc=%0d got=%h want=%h", cyc, {s, cout, ovf, zero, neg}, held_val);
          end
        end
      end
      if (in_valid && in_ready) sent++;
    end
    compared++;
    if (recv != 8) begin
      mismatched++;
      $display("[TB] FAIL b2b_count got=%0d want=8", recv);
    end
    compared++;
    if (!held) begin
      mismatched++;
      $display("[TB] FAIL stall_seen got=0 want=1");
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    extra = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) extra = 1'b1;
    end
    compared++;
    if (extra !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b_extra_beat got=1 want=0");
    end
  endtask

  task automatic test_reset_midstream();
    logic [19:0] res;
    int lat;
    bit stale;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 16'h0100 + 16'(i);
      b = 16'h0010;
      ctrl = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compared++;
    if ({out_valid, s, cout, ovf, zero, neg} !== 21'h0) begin
      mismatched++;
      $display("[TB] FAIL midreset_outputs got=%h want=000000", {out_valid, s, cout, ovf, zero, neg});
    end
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL midreset_in_ready got=%b want=1", in_ready);
    end
    stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    compared++;
    if (stale !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midreset_stale got=1 want=0");
    end
    applyStimulus(16'h0002, 16'h0004, 1'b0, res, lat);
    compared++;
    if (lat !== 4 || res !== {16'h0006, 4'b0000}) begin
      mismatched++;
      $display("[TB] FAIL midreset_fresh got=%h lat=%0d want=%h lat=4", res, lat, {16'h0006, 4'b0000});
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_boundaries();
    test_back_to_back();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipelined_add_sub.md
# pipelined_add_sub

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready stream interface and result flags. It is the next generation of the team's 4-bit ripple-carry adder/subtractor: the operand width is generic, and the carry chain is split into STAGES registered slices so wide operands close timing. It sits in the datapath between operand sources and any consumer that needs a+b or a−b plus carry, overflow, zero and negative status.

## Interface
- WIDTH, 16: operand/result width in bits; must be ≥ 2.
- STAGES, 4: number of pipeline slices; must divide WIDTH exactly (CHUNK = WIDTH/STAGES).
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, active-low and synchronous to clk.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ctrl  input  1  0 = add (a+b), 1 = subtract (a−b).
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result this cycle.
- s  output  WIDTH  result.
- cout  output  1  carry out of the MSB. For subtraction, 1 = no borrow (a ≥ b unsigned).
- ovf  output  1  signed overflow.
- zero  output  1  s == 0.
- neg  output  1  s[WIDTH-1].

## Operation
- Subtraction uses ~b with carry-in 1. Addition uses b with carry-in 0.
- Slice k adds bits [k*CHUNK +: CHUNK] with the registered carry from slice k−1. Unprocessed operand bits and completed result bits are carried forward in skew registers.
- ctrl travels with its beat. Beats never mix operations.
- ovf is taken from the final slice: carry into MSB XOR carry out of MSB.
- zero and neg are computed on the final s, after saturation if it is enabled.
- Global advance: adv = !out_valid || out_ready. in_ready = adv.
- When adv = 1, every stage register, including its valid bit, shifts one stage.
- When adv = 0, the whole pipeline holds. Bubbles are not compressed.
- A beat is accepted when in_valid && in_ready. It is delivered when out_valid && out_ready.
- Beats are never dropped or reordered.

## Timing
- Latency: a beat accepted at edge N appears with out_valid = 1 after edge N+STAGES, provided no stall occurs.
- Throughput is one beat per cycle when out_ready is held at 1.
- Stalls: while out_valid && !out_ready, s, cout, ovf, zero, neg and out_valid hold stable. in_ready stays 0 until the beat is taken.
- in_ready depends combinationally on out_ready. There is no combinational path from a, b or ctrl to any output.
- Reset, checked at a clk edge with rst_n = 0:
  - all stage valid bits clear and out_valid = 0.
  - s = 0, cout = 0, ovf = 0, zero = 0, neg = 0.
  - in_ready = 1 in the first cycle after reset.
- Reset mid-stream discards every in-flight beat. No partial result is ever presented.
- Simultaneous accept and deliver in the same cycle is legal and required for full throughput.
- Wrap-around: without saturation, results are modulo 2^WIDTH.

## Configuration
- PIPELINED_ADD_SUB_SAT_EN defined: signed saturation. When ovf = 1, s is clamped:
  - s = 2^(WIDTH−1)−1 if the true result is positive.
  - s = −2^(WIDTH−1) if the true result is negative.
  - ovf is still reported as 1. cout is unchanged.
- Undefined: s wraps and no clamp logic is built.
- Ports, latency and handshake are identical in both builds.

## Structure
- Package addsub_pkg holds:
  - op encoding constants OP_ADD = 1'b0 and OP_SUB = 1'b1.
  - a packed flags struct {cout, ovf, zero, neg}.
  - the elaboration check that WIDTH % STAGES == 0.
- Sub-module add_sub_slice: a combinational CHUNK-bit adder with cin, returning sum, cout and the carry into its MSB. It is instantiated STAGES times by a generate loop. Pipeline registers live in the parent.

## Test plan
WIDTH = 16, STAGES = 4, out_ready = 1 unless stated.
- Add: 0x0005 + 0x0003 → s = 0x0008, cout = 0, ovf = 0, zero = 0, neg = 0, exactly 4 cycles after accept.
- Subtract:
  - 0x0005 − 0x0003 → s = 0x0002, cout = 1.
  - 0x0003 − 0x0005 → s = 0xFFFE, cout = 0, neg = 1.
- Boundaries:
  - 0xFFFF + 0x0001 → s = 0x0000, cout = 1, zero = 1, ovf = 0.
  - 0x7FFF + 0x0001 → ovf = 1, s = 0x8000 (wrap build) or 0x7FFF (SAT build).
  - 0x8000 − 0x0001 → ovf = 1, s = 0x7FFF (wrap) or 0x8000 (SAT).
- Backpressure: 8 back-to-back mixed add/sub beats, with out_ready = 0 for 3 cycles mid-stream → all 8 results in order, matching a reference model; outputs stable during the stall; in_ready = 0 during the stall.
- Reset mid-stream: rst_n = 0 for one edge with 3 beats in flight → out_valid = 0 and all flags 0 next cycle, no stale beat emerges, and a fresh beat 0x0002 + 0x0004 returns 0x0006 after 4 cycles.
